// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the serializer arbiter.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int unsigned NUM_SRC   = 3;
  localparam int unsigned SRC_KEY   = 0;
  localparam int unsigned SRC_WORD  = 1;
  localparam int unsigned SRC_TWEET = 2;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational 3-way source picker, round-robin after 'last'.
// With TX_ARB_FIXED_PRIO_EN defined it is fixed priority 0 > 1 > 2 and has no 'last' input.
module rr_pick
  import tx_arb_pkg::*;
(
`ifndef TX_ARB_FIXED_PRIO_EN
  input  logic [1:0]         last,
`endif
  input  logic [NUM_SRC-1:0] pend,
  output logic [1:0]         winner,
  output logic               valid
);

`ifdef TX_ARB_FIXED_PRIO_EN
  always_comb begin
    valid  = |pend;
    winner = '0;
    if (pend[0])      winner = 2'd0;
    else if (pend[1]) winner = 2'd1;
    else if (pend[2]) winner = 2'd2;
  end
`else
  logic [1:0] cand;
  logic       found;

  // Visit last+1, last+2, last (mod 3); the first pending source wins.
  always_comb begin
    valid  = |pend;
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = 2'((32'(last) + k) % NUM_SRC);
      if (!found && pend[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: holds one byte per source and shares the byte serializer among them.
// Define TX_ARB_FIXED_PRIO_EN for fixed 0 > 1 > 2 priority instead of round-robin.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned START_TO   = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [2:0] req_en,
  input  logic [2:0] req_start,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  input  logic [7:0] req_data2,
  output logic [7:0] ser_data,
  output logic       ser_start,
  input  logic       ser_busy,
  output logic [2:0] pend,
  output logic [2:0] grant,
  output logic [2:0] overflow,
  output logic       timeout_err,
  input  logic       clear_err
);

  localparam int unsigned TO_W  = ($clog2(START_TO + 1) < 1) ? 1 : $clog2(START_TO + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t           state;
  byte_t            slot     [NUM_SRC];
  byte_t            src_data [NUM_SRC];
  logic [1:0]       win;
  logic             win_vld;
  logic [2:0]       consume;
  logic [2:0]       ovf_set;
  logic             to_fire;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
`ifndef TX_ARB_FIXED_PRIO_EN
  logic [1:0]       last;
`endif

  rr_pick u_pick (
`ifndef TX_ARB_FIXED_PRIO_EN
    .last   (last),
`endif
    .pend   (pend),
    .winner (win),
    .valid  (win_vld)
  );

  always_comb begin
    src_data[SRC_KEY]   = req_data0;
    src_data[SRC_WORD]  = req_data1;
    src_data[SRC_TWEET] = req_data2;
    consume = '0;
    if (state == IDLE && win_vld) consume[win] = 1'b1;
    ovf_set = req_en & req_start & pend & ~consume;
    to_fire = (state == WAIT_BUSY) && !ser_busy && (to_cnt == TO_LAST);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      pend        <= '0;
      grant       <= '0;
      ser_start   <= 1'b0;
      ser_data    <= '0;
      overflow    <= '0;
      timeout_err <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) slot[i] <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
      last        <= 2'd2;
`endif
    end else begin
      ser_start <= 1'b0;

      // A slot consumed on this edge can take a new byte; a full one keeps its old byte.
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!req_en[i]) begin
          pend[i] <= 1'b0;
        end else if (req_start[i] && !(pend[i] && !consume[i])) begin
          slot[i] <= src_data[i];
          pend[i] <= 1'b1;
        end else if (consume[i]) begin
          pend[i] <= 1'b0;
        end
      end

      if (clear_err)    overflow <= '0;
      else              overflow <= overflow | ovf_set;
      if (clear_err)    timeout_err <= 1'b0;
      else if (to_fire) timeout_err <= 1'b1;

      case (state)
        IDLE: begin
          if (win_vld) begin
            state     <= LAUNCH;
            ser_data  <= slot[win];
            grant     <= 3'b001 << win;
            ser_start <= 1'b1;
`ifndef TX_ARB_FIXED_PRIO_EN
            last      <= win;
`endif
          end
        end
        LAUNCH: begin
          state  <= WAIT_BUSY;
          to_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (ser_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!ser_busy) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            grant <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
